// File: rtl/prio_irq_arb_pipe.sv
// Pipelined priority interrupt arbiter: NBUS request buses of NCH channels each, fixed bus
// priority, per-bus channel priority (fixed, or round-robin when PRIO_IRQ_RR_EN is defined).
module prio_irq_arb_pipe #(
  parameter int NBUS = 3,
  parameter int NCH  = 9,
  localparam int CHW = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NBUS*NCH-1:0]  irq_i,
  input  logic [NCH-1:0]       en_i,
  input  logic                 gnt_ready_i,
  output logic                 gnt_valid_o,
  output logic [NBUS-1:0]      gnt_bus_o,
  output logic [CHW-1:0]       gnt_ch_o,
  output logic [NBUS*NCH-1:0]  pend_o,
  output logic [NBUS-1:0]      bus_act_o
);

  localparam int NREQ = NBUS * NCH;

  logic [NREQ-1:0]           pend_reg;
  logic [NREQ-1:0]           s1_reg;
  logic [NBUS-1:0]           act_reg;
  logic                      valid_reg;
  logic [NBUS-1:0]           bus_reg;
  logic [CHW-1:0]            ch_reg;

  logic                      accept;
  logic                      load;
  logic [NREQ-1:0]           clr;
  logic [NREQ-1:0]           cand;
  logic [NBUS-1:0]           bus_hit;
  logic [NBUS-1:0]           s1_any;
  logic [NBUS-1:0][CHW-1:0]  bus_ch;

  logic                      valid_next;
  logic [NBUS-1:0]           bus_next;
  logic [CHW-1:0]            ch_next;

  assign accept = valid_reg & gnt_ready_i;
  assign load   = ~valid_reg | accept;
  // The grant being accepted is removed from the candidates so it cannot be regranted.
  assign cand   = s1_reg & ~clr;

  for (genvar gi = 0; gi < NBUS; gi++) begin : g_bus
    logic [NCH-1:0] slice;
    logic [CHW-1:0] sel;

    assign slice         = cand[gi*NCH +: NCH];
    assign bus_hit[gi]   = |slice;
    assign s1_any[gi]    = |s1_reg[gi*NCH +: NCH];
    assign clr[gi*NCH +: NCH] = (accept && bus_reg[gi]) ? (NCH'(1) << ch_reg) : '0;

`ifdef PRIO_IRQ_RR_EN
    logic [CHW-1:0] ptr_reg;
    logic [CHW:0]   pos;

    always_ff @(posedge clk) begin
      if (rst) begin
        ptr_reg <= '0;
      end else if (accept && bus_reg[gi]) begin
        ptr_reg <= (ch_reg == CHW'(NCH - 1)) ? '0 : ch_reg + CHW'(1);
      end
    end

    // Scan from the far end so the position closest to ptr_reg is assigned last and wins.
    always_comb begin
      sel = '0;
      pos = '0;
      for (int k = NCH - 1; k >= 0; k--) begin
        pos = {1'b0, ptr_reg} + (CHW+1)'(k);
        if (pos >= (CHW+1)'(NCH)) pos = pos - (CHW+1)'(NCH);
        if (slice[pos[CHW-1:0]]) sel = pos[CHW-1:0];
      end
    end
`else
    always_comb begin
      sel = '0;
      for (int c = NCH - 1; c >= 0; c--) begin
        if (slice[c]) sel = CHW'(c);
      end
    end
`endif

    assign bus_ch[gi] = sel;
  end

  always_comb begin
    valid_next = |bus_hit;
    bus_next   = '0;
    ch_next    = '0;
    for (int b = NBUS - 1; b >= 0; b--) begin
      if (bus_hit[b]) begin
        bus_next = NBUS'(1) << b;
        ch_next  = bus_ch[b];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_reg  <= '0;
      s1_reg    <= '0;
      act_reg   <= '0;
      valid_reg <= 1'b0;
      bus_reg   <= '0;
      ch_reg    <= '0;
    end else begin
      pend_reg <= (pend_reg & ~clr) | irq_i;
      s1_reg   <= (pend_reg & ~clr) & {NBUS{en_i}};
      act_reg  <= s1_any;
      // Output register holds a presented grant until it is accepted.
      if (load) begin
        valid_reg <= valid_next;
        bus_reg   <= bus_next;
        ch_reg    <= ch_next;
      end
    end
  end

  assign gnt_valid_o = valid_reg;
  assign gnt_bus_o   = bus_reg;
  assign gnt_ch_o    = ch_reg;
  assign pend_o      = pend_reg;
  assign bus_act_o   = act_reg;

endmodule

// File: tb/tb_prio_irq_arb_pipe.sv
// Self-checking bench for prio_irq_arb_pipe: cycle model plus grant scoreboard, directed and random stimulus.
module tb_prio_irq_arb_pipe;
  localparam int NBUS = 3;
  localparam int NCH  = 9;
  localparam int CHW  = 4;
  localparam int N    = NBUS * NCH;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    irq = '0;
  logic [NCH-1:0]  en = 9'h1FF;
  logic            ready = 1'b0;
  logic            gnt_valid;
  logic [NBUS-1:0] gnt_bus;
  logic [CHW-1:0]  gnt_ch;
  logic [N-1:0]    pend;
  logic [NBUS-1:0] bus_act;

  prio_irq_arb_pipe #(.NBUS(NBUS), .NCH(NCH)) dut (
    .clk         (clk),
    .rst         (rst),
    .irq_i       (irq),
    .en_i        (en),
    .gnt_ready_i (ready),
    .gnt_valid_o (gnt_valid),
    .gnt_bus_o   (gnt_bus),
    .gnt_ch_o    (gnt_ch),
    .pend_o      (pend),
    .bus_act_o   (bus_act)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit mon_en = 1'b0;
  logic [NBUS+CHW-1:0] sb_q[$];

  task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N-1:0] bit_at(input int i);
    logic [N-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Reference model of the arbiter, one register per architectural state element.
  logic [N-1:0]    m_pend = '0;
  logic [N-1:0]    m_s1 = '0;
  logic [NBUS-1:0] m_act = '0;
  logic            m_valid = 1'b0;
  logic [NBUS-1:0] m_bus = '0;
  logic [CHW-1:0]  m_ch = '0;
  int              m_ptr [NBUS];

  always @(posedge clk) begin : model
    logic [N-1:0] clr;
    logic [N-1:0] cand;
    logic         acc;
    int           wb, wc, c;
    if (rst) begin
      m_pend  <= '0;
      m_s1    <= '0;
      m_act   <= '0;
      m_valid <= 1'b0;
      m_bus   <= '0;
      m_ch    <= '0;
      for (int b = 0; b < NBUS; b++) m_ptr[b] <= 0;
    end else begin
      acc = m_valid && ready;
      clr = '0;
      if (acc) for (int b = 0; b < NBUS; b++) if (m_bus[b]) clr[b*NCH + int'(m_ch)] = 1'b1;
      m_pend <= (m_pend & ~clr) | irq;
      m_s1   <= (m_pend & ~clr) & {NBUS{en}};
      for (int b = 0; b < NBUS; b++) m_act[b] <= |m_s1[b*NCH +: NCH];
      if (!m_valid || acc) begin
        cand = m_s1 & ~clr;
        wb = -1;
        wc = 0;
        for (int b = 0; b < NBUS && wb < 0; b++) begin
          for (int k = 0; k < NCH; k++) begin
`ifdef PRIO_IRQ_RR_EN
            c = (m_ptr[b] + k) % NCH;
`else
            c = k;
`endif
            if (wb < 0 && cand[b*NCH + c]) begin
              wb = b;
              wc = c;
            end
          end
        end
        m_valid <= (wb >= 0);
        m_bus   <= (wb >= 0) ? NBUS'(1 << wb) : '0;
        m_ch    <= (wb >= 0) ? CHW'(wc) : '0;
      end
      if (acc) for (int b = 0; b < NBUS; b++)
        if (m_bus[b]) m_ptr[b] <= (int'(m_ch) == NCH - 1) ? 0 : int'(m_ch) + 1;
    end
  end

  // Per-cycle compare against the model; accepted grants go through the scoreboard queue.
  always @(negedge clk) begin
    logic [NBUS+CHW-1:0] exp_g;
    if (mon_en) begin
      chk_val("valid", gnt_valid, m_valid);
      chk_val("bus", gnt_bus, m_bus);
      chk_val("ch", gnt_ch, m_ch);
      chk_val("pend", pend, m_pend);
      chk_val("bus_act", bus_act, m_act);
      if (!rst) begin
        if (m_valid && ready) sb_q.push_back({m_bus, m_ch});
        if (gnt_valid && ready) begin
          $display("grant bus=%b ch=%0d", gnt_bus, gnt_ch);
          chk_val("sb_depth", (sb_q.size() > 0), 1);
          if (sb_q.size() > 0) begin
            exp_g = sb_q.pop_front();
            chk_val("sb_grant", {gnt_bus, gnt_ch}, exp_g);
          end
        end
      end
    end
  end

  task automatic drain(input int n);
    repeat (n) begin
      tick();
      rst = 1'b0;
      irq = '0;
      en = 9'h1FF;
      ready = 1'b1;
    end
  endtask

  int rr_n;
  logic [CHW-1:0] rr_seq [4];

  initial begin
    tick();
    tick();
    mon_en = 1'b1;
    @(negedge clk);
    chk_val("rst_valid", gnt_valid, 0);
    chk_val("rst_pend", pend, 0);
    chk_val("rst_act", bus_act, 0);

    // Single request, latency from an idle output.
    tick(); rst = 1'b0; en = 9'h1FF; ready = 1'b1; irq = bit_at(13);
    tick(); irq = '0;
    @(negedge clk); chk_val("t1_lat1", gnt_valid, 0);
    tick(); @(negedge clk); chk_val("t1_lat2", gnt_valid, 0);
    tick(); @(negedge clk);
    chk_val("t1_valid", gnt_valid, 1);
    chk_val("t1_bus", gnt_bus, 3'b010);
    chk_val("t1_ch", gnt_ch, 4);
    tick(); @(negedge clk);
    chk_val("t1_pend13", pend[13], 0);
    chk_val("t1_idle", gnt_valid, 0);

    // Same channel on all three buses: bus order, back to back.
    tick(); irq = bit_at(2) | bit_at(11) | bit_at(20);
    tick(); irq = '0;
    tick();
    for (int i = 0; i < 3; i++) begin
      tick(); @(negedge clk);
      chk_val("t2_valid", gnt_valid, 1);
      chk_val("t2_bus", gnt_bus, (1 << i));
      chk_val("t2_ch", gnt_ch, 2);
    end
    tick(); @(negedge clk); chk_val("t2_idle", gnt_valid, 0);

    // Disabled channel waits, then is granted two edges after enable rises.
    tick(); en = 9'h1EF; irq = bit_at(4) | bit_at(7);
    tick(); irq = '0;
    tick();
    tick(); @(negedge clk);
    chk_val("t3_valid", gnt_valid, 1);
    chk_val("t3_ch7", gnt_ch, 7);
    tick(); en = 9'h1FF;
    @(negedge clk); chk_val("t3_gap1", gnt_valid, 0);
    tick(); @(negedge clk); chk_val("t3_gap2", gnt_valid, 0);
    tick(); @(negedge clk);
    chk_val("t3_valid4", gnt_valid, 1);
    chk_val("t3_ch4", gnt_ch, 4);

    // Back-pressure holds the grant even when a higher-priority request arrives.
    tick(); ready = 1'b0; irq = bit_at(26);
    tick(); irq = '0;
    tick();
    tick(); @(negedge clk);
    chk_val("t4_bus", gnt_bus, 3'b100);
    chk_val("t4_ch", gnt_ch, 8);
    for (int i = 0; i < 5; i++) begin
      tick(); irq = (i == 1) ? bit_at(0) : '0;
      @(negedge clk);
      chk_val("t4_hold_bus", gnt_bus, 3'b100);
      chk_val("t4_hold_ch", gnt_ch, 8);
    end
    tick(); irq = '0; ready = 1'b1;
    @(negedge clk); chk_val("t4_hold_last", gnt_bus, 3'b100);
    tick(); @(negedge clk);
    chk_val("t4_next_valid", gnt_valid, 1);
    chk_val("t4_next_bus", gnt_bus, 3'b001);
    chk_val("t4_next_ch", gnt_ch, 0);

    // Reset while a grant is outstanding with several requests pending.
    tick(); ready = 1'b0; irq = bit_at(1) | bit_at(3) | bit_at(10) | bit_at(22);
    tick(); irq = '0;
    tick();
    tick(); @(negedge clk);
    chk_val("t5_valid", gnt_valid, 1);
    chk_val("t5_ch", gnt_ch, 1);
    tick(); rst = 1'b1; irq = bit_at(5);
    tick(); rst = 1'b0; irq = '0;
    @(negedge clk);
    chk_val("t5_rst_valid", gnt_valid, 0);
    chk_val("t5_rst_bus", gnt_bus, 0);
    chk_val("t5_rst_ch", gnt_ch, 0);
    chk_val("t5_rst_pend", pend, 0);
    chk_val("t5_rst_act", bus_act, 0);
    tick(); irq = bit_at(1); ready = 1'b1;
    tick(); irq = '0;
    @(negedge clk); chk_val("t5_re_lat1", gnt_valid, 0);
    tick(); @(negedge clk); chk_val("t5_re_lat2", gnt_valid, 0);
    tick(); @(negedge clk);
    chk_val("t5_re_valid", gnt_valid, 1);
    chk_val("t5_re_ch", gnt_ch, 1);

    // Two level-held channels on bus 0 share the grant.
    tick(); irq = bit_at(0) | bit_at(1);
    rr_n = 0;
    for (int i = 0; i < 30 && rr_n < 4; i++) begin
      tick(); @(negedge clk);
      if (gnt_valid && ready) begin
        rr_seq[rr_n] = gnt_ch;
        rr_n++;
      end
    end
    chk_val("t6_count", rr_n, 4);
    for (int i = 0; i < 4; i++) chk_val("t6_seq", rr_seq[i], i % 2);
    drain(15);

    // Random traffic with back-pressure, enable masking and occasional reset.
    for (int i = 0; i < 400; i++) begin
      tick();
      irq   = N'($urandom & $urandom & $urandom);
      en    = ($urandom_range(3) == 0) ? NCH'($urandom) : 9'h1FF;
      ready = ($urandom_range(3) != 0);
      rst   = ($urandom_range(99) == 0);
    end
    drain(25);
    @(negedge clk);
    chk_val("end_pend", pend, 0);
    chk_val("sb_left", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
